// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB splitter: FSM state encoding,
// timeout counter sizing and address window arithmetic.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  // Counter must hold 0..TIMEOUT; a disabled timeout still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned to);
    return (to < 1) ? 1 : $clog2(to + 1);
  endfunction

  localparam int unsigned TO_CNT_W_DFLT = cnt_w(255);

  // First byte past the last window, computed wide so it cannot wrap at AW.
  function automatic logic [63:0] win_end(input logic [63:0] base,
                                          input int unsigned num_s,
                                          input int unsigned win_aw);
    return base + (64'(num_s) << win_aw);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational window decoder: NUM_S equal windows of 2^WIN_AW bytes
// starting at BASE_ADDR; one-hot hit or miss.
module apb_addr_decoder #(
  parameter int              AW        = 32,
  parameter int              NUM_S     = 4,
  parameter int              WIN_AW    = 12,
  parameter logic [AW-1:0]   BASE_ADDR = '0
) (
  input  logic [AW-1:0]    paddr,
  output logic [NUM_S-1:0] hit,
  output logic             miss
);
  import apb_pkg::*;

  localparam logic [63:0] END_A = win_end(64'(BASE_ADDR), NUM_S, WIN_AW);

  logic [63:0]   addr_w;
  logic          in_rng;
  logic [AW-1:0] off;
  logic [AW-1:0] win_idx;

  assign addr_w  = 64'(paddr);
  assign in_rng  = (addr_w >= 64'(BASE_ADDR)) && (addr_w < END_A);
  assign off     = paddr - BASE_ADDR;
  assign win_idx = off >> WIN_AW;

  for (genvar i = 0; i < NUM_S; i++) begin : g_hit
    assign hit[i] = in_rng && (win_idx == AW'(i));
  end

  assign miss = !in_rng;

endmodule

// File: rtl/apb_splitter.sv
// APB 1-to-NUM_S splitter / register slice with decode-miss error and
// access timeout. Every output comes straight from a flop.
module apb_splitter #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            PROT_W    = 3,
  parameter int            PSTRB_W   = 4,
  parameter int            NUM_S     = 4,
  parameter int            WIN_AW    = 12,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            TIMEOUT   = 255
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic                s_psel,
  input  logic                s_penable,
  input  logic                s_pwrite,
  input  logic [PROT_W-1:0]   s_pprot,
  input  logic [AW-1:0]       s_paddr,
  input  logic [DW-1:0]       s_pwdata,
  input  logic [PSTRB_W-1:0]  s_pstrb,
  output logic                s_pready,
  output logic                s_pslverr,
  output logic [DW-1:0]       s_prdata,
  output logic [NUM_S-1:0]    m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [PROT_W-1:0]   m_pprot,
  output logic [AW-1:0]       m_paddr,
  output logic [DW-1:0]       m_pwdata,
  output logic [PSTRB_W-1:0]  m_pstrb,
  input  logic [NUM_S-1:0]    m_pready,
  input  logic [NUM_S-1:0]    m_pslverr,
  input  logic [NUM_S*DW-1:0] m_prdata
);
  import apb_pkg::*;

  localparam int CNT_W = int'(cnt_w(TIMEOUT));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  apb_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               s_pready_q, s_pslverr_q;
  logic [DW-1:0]      s_prdata_q;
  logic [NUM_S-1:0]   m_psel_q;
  logic               m_penable_q, m_pwrite_q;
  logic [PROT_W-1:0]  m_pprot_q;
  logic [AW-1:0]      m_paddr_q;
  logic [DW-1:0]      m_pwdata_q;
  logic [PSTRB_W-1:0] m_pstrb_q;

  logic [NUM_S-1:0]   dec_hit;
  logic               dec_miss;
  logic               rdy_sel, err_sel, to_hit;
  logic [DW-1:0]      rd_sel;

  apb_addr_decoder #(
    .AW(AW), .NUM_S(NUM_S), .WIN_AW(WIN_AW), .BASE_ADDR(BASE_ADDR)
  ) u_dec (
    .paddr(s_paddr),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  // The registered one-hot select doubles as the response mux control.
  always_comb begin
    rd_sel  = '0;
    rdy_sel = 1'b0;
    err_sel = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      if (m_psel_q[i]) begin
        rd_sel  = rd_sel | m_prdata[i*DW +: DW];
        rdy_sel = rdy_sel | m_pready[i];
        err_sel = err_sel | m_pslverr[i];
      end
    end
  end

  assign to_hit = (TIMEOUT > 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_pready_q  <= 1'b0;
      s_pslverr_q <= 1'b0;
      s_prdata_q  <= '0;
      m_psel_q    <= '0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_pprot_q   <= '0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      m_pstrb_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (s_psel && !s_penable) begin
            m_pwrite_q <= s_pwrite;
            m_pprot_q  <= s_pprot;
            m_paddr_q  <= s_paddr;
            m_pwdata_q <= s_pwdata;
            m_pstrb_q  <= s_pstrb;
            if (dec_miss) begin
              state_q     <= ST_RESP;
              s_pready_q  <= 1'b1;
              s_pslverr_q <= 1'b1;
              s_prdata_q  <= '0;
            end else begin
              state_q  <= ST_SETUP;
              m_psel_q <= dec_hit;
            end
          end
        end
        ST_SETUP: begin
          m_penable_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (rdy_sel) begin
            state_q     <= ST_RESP;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            s_pready_q  <= 1'b1;
            s_pslverr_q <= err_sel;
            s_prdata_q  <= m_pwrite_q ? '0 : rd_sel;
          end else if (to_hit) begin
            state_q     <= ST_RESP;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            s_pready_q  <= 1'b1;
            s_pslverr_q <= 1'b1;
            s_prdata_q  <= '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          s_pready_q  <= 1'b0;
          s_pslverr_q <= 1'b0;
          s_prdata_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_pready  = s_pready_q;
  assign s_pslverr = s_pslverr_q;
  assign s_prdata  = s_prdata_q;
  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign m_pwrite  = m_pwrite_q;
  assign m_pprot   = m_pprot_q;
  assign m_paddr   = m_paddr_q;
  assign m_pwdata  = m_pwdata_q;
  assign m_pstrb   = m_pstrb_q;

endmodule

// File: tb/tb_apb_splitter.sv
// Directed bench for apb_splitter: hit/miss/timeout/back-to-back/reset.
module tb_apb_splitter;

  logic         pclk, preset_n;
  logic         s_psel, s_penable, s_pwrite;
  logic [2:0]   s_pprot;
  logic [31:0]  s_paddr, s_pwdata;
  logic [3:0]   s_pstrb;
  logic         s_pready, s_pslverr;
  logic [31:0]  s_prdata;
  logic [3:0]   m_psel;
  logic         m_penable, m_pwrite;
  logic [2:0]   m_pprot;
  logic [31:0]  m_paddr, m_pwdata;
  logic [3:0]   m_pstrb;
  logic [3:0]   m_pready, m_pslverr;
  logic [127:0] m_prdata;
  logic [110:0] all_out;

  int n_chk = 0;
  int n_pass = 0;

  apb_splitter #(
    .AW(32), .DW(32), .PROT_W(3), .PSTRB_W(4), .NUM_S(4),
    .WIN_AW(12), .BASE_ADDR(32'h0), .TIMEOUT(8)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_pprot(s_pprot), .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pprot(m_pprot), .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  assign all_out = {s_pready, s_pslverr, s_prdata, m_psel, m_penable, m_pwrite,
                    m_pprot, m_paddr, m_pwdata, m_pstrb};

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // One upstream transfer; cycle 0 is the setup cycle. waits<0 = slave never ready.
  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input int port, input int waits, input logic [31:0] rd,
                      input bit serr, input int exp_lat, input bit exp_err,
                      input logic [31:0] exp_rd);
    int cyc, acc;
    bit done;
    logic [3:0] mask, bad;
    mask = (port < 0) ? 4'b0 : 4'(1 << port);
    bad = '0; acc = 0; done = 0; cyc = 0;
    @(negedge pclk);
    s_psel = 1; s_penable = 0; s_pwrite = wr; s_paddr = addr;
    s_pwdata = wdata; s_pstrb = strb; s_pprot = 3'b010;
    while (!done && cyc < 40) begin
      @(negedge pclk); cyc++;
      s_penable = 1;
      bad |= m_psel & ~mask;
      if (cyc == 1) chk({tag, " psel@1"}, m_psel, mask);
      if (cyc == 2 && port >= 0) begin
        chk({tag, " penable@2"}, m_penable, 1);
        chk({tag, " paddr"}, m_paddr, addr);
        chk({tag, " pwrite"}, m_pwrite, wr);
        chk({tag, " pstrb"}, m_pstrb, strb);
        chk({tag, " pprot"}, m_pprot, 3'b010);
        if (wr) chk({tag, " pwdata"}, m_pwdata, wdata);
      end
      if (s_pready) begin
        done = 1;
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " pslverr"}, s_pslverr, exp_err);
        chk({tag, " prdata"}, s_prdata, exp_rd);
        chk({tag, " m idle"}, {m_psel, m_penable}, 0);
      end else begin
        m_pready = '0; m_pslverr = '0;
        if (m_penable && port >= 0) begin
          if (acc == waits) begin
            m_pready[port] = 1'b1;
            m_pslverr[port] = serr;
            m_prdata[port*32 +: 32] = rd;
          end
          acc++;
        end
      end
    end
    if (!done) chk({tag, " no s_pready"}, 0, 1);
    chk({tag, " psel excl"}, bad, 0);
    m_pready = '0; m_pslverr = '0;
  endtask

  initial begin
    preset_n = 0;
    s_psel = 0; s_penable = 0; s_pwrite = 0; s_pprot = '0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0;
    m_pready = '0; m_pslverr = '0; m_prdata = '0;
    repeat (2) @(negedge pclk);
    chk("reset outs", all_out, 0);
    preset_n = 1;
    @(negedge pclk);
    chk("idle outs", all_out, 0);

    xfer("wr p1",   1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 1,  0, 32'h1234_5678, 0, 3,  0, 32'h0);
    xfer("rd p3",   0, 32'h0000_3010, 32'h0,         4'hF, 3,  2, 32'hDEAD_BEEF, 0, 5,  0, 32'hDEAD_BEEF);
    xfer("miss",    0, 32'h0000_4000, 32'h0,         4'hF, -1, 0, 32'h0,         0, 1,  1, 32'h0);
    xfer("timeout", 0, 32'h0000_0000, 32'h0,         4'hF, 0, -1, 32'h0000_0055, 0, 11, 1, 32'h0);
    xfer("to rdy",  0, 32'h0000_0008, 32'h0,         4'h3, 0,  8, 32'hCAFE_F00D, 0, 11, 0, 32'hCAFE_F00D);
    xfer("slverr",  0, 32'h0000_1FFC, 32'h0,         4'hF, 1,  1, 32'h0BAD_F00D, 1, 4,  1, 32'h0BAD_F00D);
    xfer("b2b wr",  1, 32'h0000_2040, 32'h1357_9BDF, 4'h5, 2,  0, 32'hFFFF_FFFF, 0, 3,  0, 32'h0);
    xfer("b2b rd",  0, 32'h0000_0FFC, 32'h0,         4'hF, 0,  0, 32'h600D_CAFE, 0, 3,  0, 32'h600D_CAFE);

    // Reset in the middle of ACCESS: outputs clear at once, no response follows.
    @(negedge pclk);
    s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 32'h0000_0100;
    @(negedge pclk);
    s_penable = 1;
    @(negedge pclk);
    chk("rst pre penable", m_penable, 1);
    #2 preset_n = 0;
    #1 chk("rst async outs", all_out, 0);
    @(negedge pclk);
    preset_n = 1; s_psel = 0; s_penable = 0;
    @(negedge pclk);
    chk("rst no resp", all_out, 0);

    xfer("post rst", 0, 32'h0000_3000, 32'h0, 4'hF, 3, 0, 32'h7777_1111, 0, 3, 0, 32'h7777_1111);
    @(negedge pclk);
    s_psel = 0; s_penable = 0;
    @(negedge pclk);
    chk("final idle", {s_pready, m_psel, m_penable}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
